// File: rtl/fifo_asym_wr.sv
// Synchronous FIFO whose write port pushes RATIO narrow words per accepted write
// and whose read port pops one narrow word, with first-word fall-through.
module fifo_asym_wr #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int RATIO      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr,
    input  logic [DATA_WIDTH*RATIO-1:0] w_data,
    input  logic                        rd,
    input  logic                        err_clr,
    output logic [DATA_WIDTH-1:0]       r_data,
    output logic                        full,
    output logic                        empty,
    output logic [ADDR_WIDTH:0]         count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int                    DEPTH      = 1 << ADDR_WIDTH;
    localparam int                    CW         = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         FULL_LIMIT = CW'(DEPTH - RATIO);
    localparam logic [CW-1:0]         RATIO_C    = CW'(RATIO);
    // RATIO == DEPTH truncates to 0, which is exactly the modulo-DEPTH step.
    localparam logic [ADDR_WIDTH-1:0] WPTR_STEP  = ADDR_WIDTH'(RATIO);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] w_slice   [RATIO];
    logic [ADDR_WIDTH-1:0] slot_addr [RATIO];

    assign full  = (count_q > FULL_LIMIT);
    assign empty = (count_q == '0);

    // Both accepts use pre-edge flags only, so a same-cycle pop never frees room
    // for a push and a same-cycle push never feeds a pop.
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    // Slice k of the wide word goes to (wptr + k) mod DEPTH; the address add
    // wraps naturally, so a write may straddle the end of the array.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
            assign w_slice[gi]   = w_data[DATA_WIDTH*gi +: DATA_WIDTH];
            assign slot_addr[gi] = wptr_q + ADDR_WIDTH'(gi);
        end
    endgenerate

    // Storage is deliberately not reset; the full rule guarantees these slots
    // never include the occupied head at rptr.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < RATIO; k++) begin
                mem_q[slot_addr[k]] <= w_slice[k];
            end
        end
    end

    assign r_data = mem_q[rptr_q];

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q & ~err_clr;
        underflow_d = underflow_q & ~err_clr;

        if (wr_ok) begin
            wptr_d = wptr_q + WPTR_STEP;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + (wr_ok ? RATIO_C : '0) - (rd_ok ? CW'(1) : '0);

        // A new error in the same cycle as err_clr leaves the flag set.
        if (wr & full) begin
            overflow_d = 1'b1;
        end
        if (rd & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_asym_wr.sv
// Directed bench for fifo_asym_wr: a RATIO=2 and a RATIO=3 instance, each checked
// every cycle against a queue-level model, plus literal expectations.
module tb_fifo_asym_wr;

    logic        clk;
    logic        reset_n;
    logic        wr_s  [2];
    logic        rd_s  [2];
    logic        clr_s [2];
    logic [23:0] wd    [2];
    logic [7:0]  rdat  [2];
    logic        fl    [2];
    logic        em    [2];
    logic [3:0]  cnt   [2];
    logic        ov    [2];
    logic        un    [2];

    int tests_run = 0;
    int tests_failed = 0;

    fifo_asym_wr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RATIO(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .wr(wr_s[0]), .w_data(wd[0][15:0]),
        .rd(rd_s[0]), .err_clr(clr_s[0]), .r_data(rdat[0]), .full(fl[0]),
        .empty(em[0]), .count(cnt[0]), .overflow(ov[0]), .underflow(un[0])
    );

    fifo_asym_wr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RATIO(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .wr(wr_s[1]), .w_data(wd[1]),
        .rd(rd_s[1]), .err_clr(clr_s[1]), .r_data(rdat[1]), .full(fl[1]),
        .empty(em[1]), .count(cnt[1]), .overflow(ov[1]), .underflow(un[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an unbounded-ish word list per instance plus the two sticky flags.
    int         ratio [2] = '{2, 3};
    logic [7:0] mbuf  [2][256];
    int         mhead [2];
    int         msize [2];
    bit         mov   [2];
    bit         mun   [2];

    always @(posedge clk or negedge reset_n) begin
        bit m_full, m_empty, ok_w, ok_r;
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                mhead[d] = 0; msize[d] = 0; mov[d] = 0; mun[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_full  = (msize[d] + ratio[d] > 8);
                m_empty = (msize[d] == 0);
                ok_w = wr_s[d] && !m_full;
                ok_r = rd_s[d] && !m_empty;
                if (ok_r) begin
                    mhead[d] = (mhead[d] + 1) % 256;
                    msize[d] = msize[d] - 1;
                end
                if (ok_w) begin
                    for (int k = 0; k < ratio[d]; k++) begin
                        mbuf[d][(mhead[d] + msize[d]) % 256] = wd[d][8*k +: 8];
                        msize[d] = msize[d] + 1;
                    end
                end
                mov[d] = (mov[d] && !clr_s[d]) || (wr_s[d] && m_full);
                mun[d] = (mun[d] && !clr_s[d]) || (rd_s[d] && m_empty);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("dut%0d.count", d), int'(cnt[d]), msize[d]);
                chk($sformatf("dut%0d.empty", d), int'(em[d]), int'(msize[d] == 0));
                chk($sformatf("dut%0d.full", d), int'(fl[d]), int'(msize[d] + ratio[d] > 8));
                chk($sformatf("dut%0d.overflow", d), int'(ov[d]), int'(mov[d]));
                chk($sformatf("dut%0d.underflow", d), int'(un[d]), int'(mun[d]));
                if (msize[d] != 0)
                    chk($sformatf("dut%0d.r_data", d), int'(rdat[d]), int'(mbuf[d][mhead[d]]));
            end
        end
    end

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic op(input int d, input bit w, input logic [23:0] data, input bit r, input bit c);
        wr_s[d] = w; wd[d] = data; rd_s[d] = r; clr_s[d] = c;
        @(posedge clk);
        @(negedge clk);
        wr_s[d] = 1'b0; rd_s[d] = 1'b0; clr_s[d] = 1'b0;
        $display("[TB] dut%0d wr=%0b data=%h rd=%0b clr=%0b -> count=%0d full=%0b empty=%0b ov=%0b un=%0b r_data=%h",
                 d, w, data, r, c, cnt[d], fl[d], em[d], ov[d], un[d], rdat[d]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wr_s[d] = 0; rd_s[d] = 0; clr_s[d] = 0; wd[d] = '0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1. reset then idle
        chk("reset.full", int'(fl[0]), 0);
        chk("reset.empty", int'(em[0]), 1);
        chk("reset.count", int'(cnt[0]), 0);
        chk("reset.overflow", int'(ov[0]), 0);
        chk("reset.underflow", int'(un[0]), 0);

        // 2. single write and drain
        op(0, 1, 24'h00BBAA, 0, 0);
        chk("wr1.count", int'(cnt[0]), 2);
        chk("wr1.empty", int'(em[0]), 0);
        chk("wr1.r_data", int'(rdat[0]), 'hAA);
        op(0, 0, 0, 1, 0);
        chk("rd1.r_data", int'(rdat[0]), 'hBB);
        chk("rd1.count", int'(cnt[0]), 1);
        op(0, 0, 0, 1, 0);
        chk("rd2.empty", int'(em[0]), 1);
        chk("rd2.count", int'(cnt[0]), 0);

        // 3. fill and overflow
        op(0, 1, 24'h000201, 0, 0);
        op(0, 1, 24'h000403, 0, 0);
        op(0, 1, 24'h000605, 0, 0);
        op(0, 1, 24'h000807, 0, 0);
        chk("fill.count", int'(cnt[0]), 8);
        chk("fill.full", int'(fl[0]), 1);
        op(0, 1, 24'h00FFFF, 0, 0);
        chk("ovf.overflow", int'(ov[0]), 1);
        chk("ovf.count", int'(cnt[0]), 8);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d.r_data", i), int'(rdat[0]), i);
            op(0, 0, 0, 1, 0);
        end
        chk("drain.empty", int'(em[0]), 1);

        // 4. full-boundary simultaneity, then set-wins on err_clr
        for (int i = 0; i < 4; i++) op(0, 1, 24'h001000 + 24'(i), 0, 0);
        op(0, 0, 0, 1, 0);
        chk("c7.count", int'(cnt[0]), 7);
        chk("c7.full", int'(fl[0]), 1);
        op(0, 1, 24'h002211, 1, 1);
        chk("simul.count", int'(cnt[0]), 6);
        chk("simul.overflow", int'(ov[0]), 1);
        op(0, 1, 24'h002211, 0, 0);
        chk("after.count", int'(cnt[0]), 8);
        op(0, 1, 24'h003333, 0, 1);
        chk("setwins.overflow", int'(ov[0]), 1);
        op(0, 0, 0, 0, 1);
        chk("clr.overflow", int'(ov[0]), 0);
        for (int i = 0; i < 8; i++) op(0, 0, 0, 1, 0);
        chk("drain4.empty", int'(em[0]), 1);

        // 5. wrap and straddle on the RATIO=3 instance
        op(1, 1, 24'h030201, 0, 0);
        op(1, 1, 24'h060504, 0, 0);
        chk("r3.count", int'(cnt[1]), 6);
        chk("r3.full", int'(fl[1]), 1);
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("r3.drain%0d", i), int'(rdat[1]), i);
            op(1, 0, 0, 1, 0);
        end
        op(1, 1, 24'hCCBBAA, 0, 0);
        chk("strad.r_data0", int'(rdat[1]), 'hAA);
        chk("strad.count", int'(cnt[1]), 3);
        op(1, 0, 0, 1, 0);
        chk("strad.r_data1", int'(rdat[1]), 'hBB);
        op(1, 0, 0, 1, 0);
        chk("strad.r_data2", int'(rdat[1]), 'hCC);
        op(1, 0, 0, 1, 0);
        chk("strad.empty", int'(em[1]), 1);

        // 6. underflow, err_clr, asynchronous reset mid-cycle
        op(0, 0, 0, 1, 0);
        chk("unf.underflow", int'(un[0]), 1);
        chk("unf.count", int'(cnt[0]), 0);
        op(0, 0, 0, 0, 1);
        chk("unfclr.underflow", int'(un[0]), 0);
        op(0, 1, 24'h000102, 0, 0);
        op(0, 1, 24'h000304, 0, 0);
        op(0, 1, 24'h000506, 0, 0);
        op(0, 0, 0, 1, 0);
        chk("pre_rst.count", int'(cnt[0]), 5);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.count", int'(cnt[0]), 0);
        chk("arst.empty", int'(em[0]), 1);
        @(negedge clk);
        reset_n = 1'b1;
        op(0, 1, 24'h00BEEF, 0, 0);
        chk("post_rst.r_data", int'(rdat[0]), 'hEF);
        chk("post_rst.count", int'(cnt[0]), 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_asym_wr.md
Name: fifo_asym_wr

Overview:
- Synchronous FIFO with an asymmetric-width write port.
- Each accepted write pushes RATIO narrow words in one cycle. Each accepted read pops one narrow word.
- Internal storage is a 2^ADDR_WIDTH x DATA_WIDTH register array with asynchronous (combinational) read at the head.
- Sits between a wide producer (e.g. a 16-bit datapath) and a narrow byte-serial consumer (e.g. UART TX). Adds full/empty/count tracking and sticky error flags.

Parameters:
- DATA_WIDTH, 8, width of one stored/read word.
- ADDR_WIDTH, 3, log2 of storage depth; DEPTH = 2**ADDR_WIDTH words.
- RATIO, 2, narrow words per write; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr  input  1  write request.
- w_data  input  DATA_WIDTH*RATIO  write data; slice k (bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]) is the k-th word pushed.
- rd  input  1  read request (pop).
- err_clr  input  1  synchronous clear of overflow/underflow.
- r_data  output  DATA_WIDTH  word at head; valid when empty=0.
- full  output  1  fewer than RATIO free slots.
- empty  output  1  no stored words.
- count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - Write/read pointers = 0, count = 0, empty = 1, full = 0 (RATIO <= DEPTH), overflow = 0, underflow = 0.
  - Storage array is not reset. r_data is don't-care while empty.
- Pointers: ADDR_WIDTH bits each, wrap modulo DEPTH. count is a registered counter. empty = (count==0). full = (count > DEPTH-RATIO). Both are combinational from count.
- Write accept: wr_ok = wr & ~full, evaluated on the pre-edge count.
  - On wr_ok, slot (wptr+k) mod DEPTH <= slice k for k = 0..RATIO-1.
  - Then wptr <= (wptr+RATIO) mod DEPTH.
  - A write may straddle the array end; the low slice lands at the highest addresses.
- Read accept: rd_ok = rd & ~empty.
  - On rd_ok, rptr <= (rptr+1) mod DEPTH.
  - r_data = mem[rptr], combinational (first-word fall-through).
  - The first word of a write is visible on r_data the cycle after the write edge.
- Count update: count <= count + (wr_ok ? RATIO : 0) - (rd_ok ? 1 : 0).
- Simultaneous wr and rd:
  - Each is qualified independently on pre-edge flags.
  - A read in the same cycle does NOT unblock a write while full=1.
  - A write in the same cycle does NOT unblock a read while empty=1.
- Rejected write (wr & full): storage, wptr and count unchanged; overflow <= 1.
- Rejected read (rd & empty): rptr and count unchanged; underflow <= 1.
- Error flags:
  - Sticky until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the flag ends 1 (set wins).
- No read-during-write hazard: a write never touches the occupied slot at rptr, because the full rule prevents it.
- Invariants: count never exceeds DEPTH; (wptr - rptr) mod DEPTH == count mod DEPTH.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, RATIO=2 unless noted):
1. Reset then idle: full=0, empty=1, count=0, overflow=0, underflow=0.
2. Single write and drain:
   - wr with w_data=0xBBAA -> next cycle count=2, empty=0, r_data=0xAA.
   - rd -> r_data=0xBB, count=1.
   - rd -> empty=1, count=0.
3. Fill and overflow:
   - Writes 0x0201, 0x0403, 0x0605, 0x0807 -> count=8, full=1.
   - Write 0xFFFF -> dropped, overflow=1, count=8.
   - 8 reads return 0x01..0x08 in order; empty=1.
4. Full-boundary simultaneity:
   - At count=7 (full=1), assert wr=1 (0x2211) and rd=1 together -> write rejected, one word popped, count=6, overflow=1.
   - Next wr=1 (0x2211) alone -> accepted, count=8.
5. Wrap and straddle (RATIO=3):
   - Push 6 words, pop 6 words; rptr=wptr=6.
   - Write 0xCCBBAA -> slots 6, 7, 0; reads return 0xAA, 0xBB, 0xCC.
6. Underflow, err_clr and async reset:
   - rd at empty -> underflow=1, count=0.
   - err_clr=1 -> underflow=0.
   - With count=5, drop reset_n mid-cycle -> count=0, empty=1 immediately, before the next edge.
